// File: rtl/rpc2_ctrl_wdat_split.sv
// rpc2_ctrl_wdat_split: splits 32-bit write beats into 16-bit halfword pushes for the write-data FIFO
module rpc2_ctrl_wdat_split #(
  parameter int LEN_BITS = 9
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [LEN_BITS-1:0] cmd_len,
  input  logic                cmd_odd,
  input  logic                s_wvalid,
  output logic                s_wready,
  input  logic [31:0]         s_wdata,
  input  logic [3:0]          s_wstrb,
  input  logic                s_wlast,
  output logic                fifo_wr_en,
  output logic [18:0]         fifo_wr_data,
  input  logic                fifo_full,
  output logic                busy,
  output logic                len_err
);
  typedef enum logic {IDLE, XFER} state_t;
  state_t              state_q, state_d;
  logic [LEN_BITS-1:0] remain_q, remain_d;
  logic                half_q, half_d, len_err_q, len_err_d;
  logic                accept, emit, last, step;
  always_comb begin
    cmd_ready    = state_q == IDLE;
    busy         = state_q == XFER;
    accept       = cmd_ready & cmd_valid;
    emit         = busy & s_wvalid & ~fifo_full;
    last         = remain_q == '0;
    step         = emit & ~last;
    fifo_wr_en   = emit;
    s_wready     = emit & (half_q | last);
    fifo_wr_data = {last, half_q ? s_wstrb[3:2] : s_wstrb[1:0], half_q ? s_wdata[31:16] : s_wdata[15:0]};
    state_d      = accept ? XFER : (emit & last) ? IDLE : state_q;
    remain_d     = accept ? cmd_len : step ? remain_q - LEN_BITS'(1) : remain_q;
    half_d       = accept ? cmd_odd : step ? ~half_q : half_q;
    len_err_d    = s_wready & (s_wlast ^ last);
    len_err      = len_err_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      remain_q  <= '0;
      half_q    <= 1'b0;
      len_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      remain_q  <= remain_d;
      half_q    <= half_d;
      len_err_q <= len_err_d;
    end
  end
endmodule

// File: tb/tb_rpc2_ctrl_wdat_split.sv
// tb_rpc2_ctrl_wdat_split: directed vector table plus hand sequences for rpc2_ctrl_wdat_split
module tb_rpc2_ctrl_wdat_split;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [8:0]  cmd_len = '0;
  logic        cmd_odd = 1'b0;
  logic        s_wvalid = 1'b0;
  logic        s_wready;
  logic [31:0] s_wdata = '0;
  logic [3:0]  s_wstrb = '0;
  logic        s_wlast = 1'b0;
  logic        fifo_wr_en;
  logic [18:0] fifo_wr_data;
  logic        fifo_full = 1'b0;
  logic        busy;
  logic        len_err;
  int          checks = 0;
  int          failures = 0;
  typedef struct packed {
    logic        cv;
    logic [8:0]  len;
    logic        odd;
    logic        wv;
    logic [31:0] wd;
    logic [3:0]  ws;
    logic        wl;
    logic        full;
    logic        e_crdy;
    logic        e_busy;
    logic        e_wrdy;
    logic        e_wen;
    logic [18:0] e_wdat;
    logic        e_err;
  } vec_t;
  vec_t vecs[$];
  always #5 clk = ~clk;
  rpc2_ctrl_wdat_split #(.LEN_BITS(9)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
    .cmd_odd(cmd_odd), .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_wlast(s_wlast), .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data), .fifo_full(fifo_full),
    .busy(busy), .len_err(len_err)
  );
  function automatic vec_t mk(logic cv, logic [8:0] len, logic odd, logic wv, logic [31:0] wd, logic [3:0] ws,
                              logic wl, logic full, logic crdy, logic bsy, logic wrdy, logic wen,
                              logic [18:0] wdat, logic err);
    return '{cv, len, odd, wv, wd, ws, wl, full, crdy, bsy, wrdy, wen, wdat, err};
  endfunction
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic chk_ctl(string tag, logic crdy, logic bsy, logic wrdy, logic wen, logic err);
    chk({tag, ".cmd_ready"}, 32'(cmd_ready), 32'(crdy));
    chk({tag, ".busy"}, 32'(busy), 32'(bsy));
    chk({tag, ".s_wready"}, 32'(s_wready), 32'(wrdy));
    chk({tag, ".fifo_wr_en"}, 32'(fifo_wr_en), 32'(wen));
    chk({tag, ".len_err"}, 32'(len_err), 32'(err));
  endtask
  initial begin
    // test 1: even start, two full beats
    vecs.push_back(mk(1, 3, 0, 0, 32'h0, 4'h0, 0, 0, 1, 0, 0, 0, 19'h0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 32'hBBBBAAAA, 4'hF, 0, 0, 0, 1, 0, 1, 19'h3AAAA, 0));
    vecs.push_back(mk(0, 0, 0, 1, 32'hBBBBAAAA, 4'hF, 0, 0, 0, 1, 1, 1, 19'h3BBBB, 0));
    vecs.push_back(mk(0, 0, 0, 1, 32'hDDDDCCCC, 4'hF, 1, 0, 0, 1, 0, 1, 19'h3CCCC, 0));
    vecs.push_back(mk(0, 0, 0, 1, 32'hDDDDCCCC, 4'hF, 1, 0, 0, 1, 1, 1, 19'h7DDDD, 0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0, 4'h0, 0, 0, 1, 0, 0, 0, 19'h0, 0));
    // test 2: odd start
    vecs.push_back(mk(1, 2, 1, 0, 32'h0, 4'h0, 0, 0, 1, 0, 0, 0, 19'h0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 32'h11110000, 4'hC, 0, 0, 0, 1, 1, 1, 19'h31111, 0));
    vecs.push_back(mk(0, 0, 0, 1, 32'h33332222, 4'hF, 1, 0, 0, 1, 0, 1, 19'h32222, 0));
    vecs.push_back(mk(0, 0, 0, 1, 32'h33332222, 4'hF, 1, 0, 0, 1, 1, 1, 19'h73333, 0));
    // test 3: single halfword from the lower half consumes its beat
    vecs.push_back(mk(1, 0, 0, 0, 32'h0, 4'h0, 0, 0, 1, 0, 0, 0, 19'h0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 32'hFFFF5A5A, 4'h3, 1, 0, 0, 1, 1, 1, 19'h75A5A, 0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0, 4'h0, 0, 0, 1, 0, 0, 0, 19'h0, 0));
    // test 4: full stall, zero mask pushed, cmd_valid ignored while busy
    vecs.push_back(mk(1, 3, 0, 0, 32'h0, 4'h0, 0, 0, 1, 0, 0, 0, 19'h0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 32'hBBBBAAAA, 4'h0, 0, 0, 0, 1, 0, 1, 19'h0AAAA, 0));
    vecs.push_back(mk(1, 7, 1, 1, 32'hBBBBAAAA, 4'h0, 0, 1, 0, 1, 0, 0, 19'h0, 0));
    vecs.push_back(mk(1, 7, 1, 1, 32'hBBBBAAAA, 4'h0, 0, 1, 0, 1, 0, 0, 19'h0, 0));
    vecs.push_back(mk(1, 7, 1, 1, 32'hBBBBAAAA, 4'h0, 0, 1, 0, 1, 0, 0, 19'h0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 32'hBBBBAAAA, 4'h0, 0, 0, 0, 1, 1, 1, 19'h0BBBB, 0));
    vecs.push_back(mk(0, 0, 0, 0, 32'hDDDDCCCC, 4'hF, 1, 0, 0, 1, 0, 0, 19'h0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 32'hDDDDCCCC, 4'hF, 1, 0, 0, 1, 0, 1, 19'h3CCCC, 0));
    vecs.push_back(mk(0, 0, 0, 1, 32'hDDDDCCCC, 4'hF, 1, 0, 0, 1, 1, 1, 19'h7DDDD, 0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0, 4'h0, 0, 0, 1, 0, 0, 0, 19'h0, 0));
    // test 5: early last then missing last
    vecs.push_back(mk(1, 3, 0, 0, 32'h0, 4'h0, 0, 0, 1, 0, 0, 0, 19'h0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 32'hBBBBAAAA, 4'hF, 1, 0, 0, 1, 0, 1, 19'h3AAAA, 0));
    vecs.push_back(mk(0, 0, 0, 1, 32'hBBBBAAAA, 4'hF, 1, 0, 0, 1, 1, 1, 19'h3BBBB, 0));
    vecs.push_back(mk(0, 0, 0, 1, 32'hDDDDCCCC, 4'hF, 0, 0, 0, 1, 0, 1, 19'h3CCCC, 1));
    vecs.push_back(mk(0, 0, 0, 1, 32'hDDDDCCCC, 4'hF, 0, 0, 0, 1, 1, 1, 19'h7DDDD, 0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0, 4'h0, 0, 0, 1, 0, 0, 0, 19'h0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0, 4'h0, 0, 0, 1, 0, 0, 0, 19'h0, 0));
    s_wvalid = 1'b1;
    s_wdata = 32'h12345678;
    repeat (2) @(negedge clk);
    chk_ctl("reset", 1, 0, 0, 0, 0);
    rst_n = 1'b1;
    s_wvalid = 1'b0;
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      {cmd_valid, cmd_len, cmd_odd, s_wvalid, s_wdata, s_wstrb, s_wlast, fifo_full} =
        {vecs[i].cv, vecs[i].len, vecs[i].odd, vecs[i].wv, vecs[i].wd, vecs[i].ws, vecs[i].wl, vecs[i].full};
      #1;
      chk_ctl($sformatf("v%0d", i), vecs[i].e_crdy, vecs[i].e_busy, vecs[i].e_wrdy, vecs[i].e_wen, vecs[i].e_err);
      if (vecs[i].e_wen) chk($sformatf("v%0d.wr_data", i), 32'(fifo_wr_data), 32'(vecs[i].e_wdat));
    end
    // test 6: async reset mid-transfer, then a fresh two-halfword command
    @(negedge clk);
    {cmd_valid, cmd_len, cmd_odd, s_wvalid} = {1'b1, 9'd5, 1'b0, 1'b0};
    @(negedge clk);
    {cmd_valid, s_wvalid, s_wdata, s_wstrb, s_wlast} = {1'b0, 1'b1, 32'h22221111, 4'hF, 1'b0};
    #1;
    chk("rst6.push1", 32'(fifo_wr_data), 32'h31111);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_ctl("rst6.abort", 1, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    {cmd_valid, cmd_len, cmd_odd, s_wvalid} = {1'b1, 9'd1, 1'b0, 1'b0};
    #1;
    chk_ctl("rst6.idle", 1, 0, 0, 0, 0);
    @(negedge clk);
    {cmd_valid, s_wvalid, s_wdata, s_wstrb, s_wlast} = {1'b0, 1'b1, 32'h44443333, 4'hF, 1'b1};
    #1;
    chk_ctl("rst6.h0", 0, 1, 0, 1, 0);
    chk("rst6.h0.data", 32'(fifo_wr_data), 32'h33333);
    @(negedge clk);
    #1;
    chk_ctl("rst6.h1", 0, 1, 1, 1, 0);
    chk("rst6.h1.data", 32'(fifo_wr_data), 32'h74444);
    @(negedge clk);
    s_wvalid = 1'b0;
    #1;
    chk_ctl("rst6.done", 1, 0, 0, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rpc2_ctrl_wdat_split.md
Name: rpc2_ctrl_wdat_split

Overview:
Upstream feeder of the controller's write-data sync FIFO.
- Accepts 32-bit AXI-style write beats with byte strobes.
- Splits each beat into 16-bit halfwords, low half first, honouring a start-at-upper-half offset and an exact halfword count per command.
- Pushes {last, mask[1:0], data[15:0]} entries into the FIFO, one per cycle, never writing while the FIFO reports full.

Parameters:
- LEN_BITS, 9: width of cmd_len and of the internal remaining counter. Max command = 2^LEN_BITS halfwords, which matches the default 512-entry FIFO.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_len  in  LEN_BITS  halfword count minus 1 (0 = one halfword)
- cmd_odd  in  1  first halfword taken from s_wdata[31:16]
- s_wvalid  in  1  write beat valid
- s_wready  out  1  write beat consumed this cycle
- s_wdata  in  32  write data
- s_wstrb  in  4  byte strobes
- s_wlast  in  1  last beat of the burst
- fifo_wr_en  out  1  FIFO push
- fifo_wr_data  out  19  {last, mask[1:0], data[15:0]}
- fifo_full  in  1  registered FIFO full flag
- busy  out  1  transfer in progress
- len_err  out  1  one-cycle pulse on s_wlast / length mismatch

Behaviour:
Interface:
- Reset rst_n, asynchronous, active-low; clock clk.
- On reset: state=IDLE, remain=0, half=0, len_err=0. Hence cmd_ready=1, busy=0, s_wready=0, fifo_wr_en=0.

States:
- IDLE
  - cmd_ready=1.
  - On cmd_valid: remain<=cmd_len, half<=cmd_odd, go to XFER.
- XFER
  - cmd_ready=0, busy=1.

Emit (XFER only, combinational):
- emit = s_wvalid & ~fifo_full.
- fifo_wr_en = emit.
- fifo_wr_data.data: s_wdata[31:16] if half=1, else s_wdata[15:0].
- fifo_wr_data.mask: s_wstrb[3:2] if half=1, else s_wstrb[1:0].
- fifo_wr_data.last = (remain==0).
- Mask is passed through unmodified; a zero mask is still pushed.

Beat consumption:
- s_wready = emit & (half | remain==0).
- The final halfword always consumes its beat, even if it came from the lower half.

On emit:
- remain==0: return to IDLE.
- Otherwise: remain<=remain-1 and half<=~half.
- Throughput: one halfword per cycle. Zero latency from beat valid to push. Next command is accepted the cycle after the final push.

Flow control:
- fifo_full=1 or s_wvalid=0 stalls XFER: no push, no consumption, no register change.
- fifo_full is sampled as-is. The FIFO's full already accounts for a push in the same cycle, so back-to-back pushes up to capacity are legal.

len_err (registered, asserted the cycle after the event):
- Pulses when a beat is consumed with s_wlast=1 and remain!=0 (early last).
- Pulses when the final beat is consumed with s_wlast=0 (missing last).
- Counting is unaffected: exactly cmd_len+1 halfwords are always pushed.

Other rules:
- cmd_valid during XFER is ignored (not accepted).
- Width arithmetic: remain is a LEN_BITS-bit down-counter, no wrap. It never decrements at 0.
- Async reset mid-transfer aborts immediately to IDLE. Partially consumed beats are not replayed; the FIFO is reset separately.

Test Plan:
1. cmd_len=3, cmd_odd=0; beats 0xBBBBAAAA/strb 0xF, then 0xDDDDCCCC/strb 0xF/wlast=1; fifo_full=0 -> 4 consecutive pushes, data AAAA, BBBB, CCCC, DDDD, mask 3, last=1 only on the 4th. s_wready high in cycles 2 and 4. len_err stays 0. cmd_ready returns to 1 in cycle 5.
2. cmd_len=2, cmd_odd=1; beats 0x11110000/strb 0xC, then 0x33332222/strb 0xF/wlast=1 -> pushes 1111 (mask 3), 2222 (mask 3), 3333 (mask 3, last=1). First beat consumed in cycle 1; second beat consumed in cycle 3.
3. cmd_len=0, cmd_odd=0; beat 0xFFFF5A5A/strb 0x3/wlast=1 -> single push {1, 2'b11, 0x5A5A}. Beat consumed the same cycle. Back to IDLE.
4. cmd_len=3 with fifo_full held high for 3 cycles after the 1st push -> fifo_wr_en=0 and s_wready=0 during the stall. Remaining 3 pushes follow with values unchanged and order preserved.
5. cmd_len=3; first beat with wlast=1, second beat with wlast=0 -> len_err pulses after the 1st beat and after the 2nd beat. All 4 halfwords are still pushed.
6. rst_n pulsed low after 1 push of a cmd_len=5 transfer -> busy=0, cmd_ready=1, fifo_wr_en=0 immediately. A new cmd_len=1 command then completes normally with 2 pushes.
